mem_port_ctrl: RTL
==================

// Module: mem_port_ctrl
// PURPOSE
//  Initiator side of the main-memory port: turns single-word store and 1..16-word burst load requests into the
//  ram read/write/addr/BusMuxOut strobes. Captures ram MDataIn into an internal MDR and returns it on a response stream.
//  Sits between the control unit / program loader and ram; ram has 1-cycle registered read, write has priority.
// PARAMETERS
//  ADDR_W  9   word-address width (512-word ram)
//  DATA_W  32  data width
//  LEN_W   4   burst length field width; burst = req_len+1 words
// PORTS
//  clock      in   1       single clock, all state on posedge
//  clear_n    in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept (1 only in IDLE)
//  req_we     in   1       1 = store, 0 = load
//  req_addr   in   ADDR_W  start word address
//  req_wdata  in   DATA_W  store data
//  req_len    in   LEN_W   load words minus one; ignored for stores
//  rsp_valid  out  1       one load word on rsp_data this cycle (no backpressure)
//  rsp_data   out  DATA_W  load data (MDR)
//  rsp_last   out  1       marks final word of a burst
//  wr_done    out  1       1-cycle pulse: store committed
//  busy       out  1       ~IDLE or response pipeline non-empty
//  ram_read   out  1       to ram read
//  ram_write  out  1       to ram write
//  ram_addr   out  ADDR_W  to ram addr (MAR)
//  ram_wdata  out  DATA_W  to ram BusMuxOut
//  ram_rdata  in   DATA_W  from ram MDataIn
// BEHAVIOUR
//  - Reset (async, clear_n=0): state IDLE; req_ready=1 after release; all other outputs 0; MAR/MDR/count = 0.
//  - All outputs registered. ram_read and ram_write never high in the same cycle.
//  - Handshake: accept on posedge with req_valid&req_ready; addr/wdata/len/we captured then; inputs ignored otherwise.
//  - FSM: IDLE -> WRITE (we=1) | READ (we=0). WRITE -> IDLE after 1 cycle. READ -> DRAIN after len+1 issue cycles.
//    DRAIN -> IDLE when response pipeline empty.
//  - Store timing: accept edge = cycle 0; cycle 1 ram_write=1, ram_addr=A, ram_wdata=D; cycle 2 wr_done=1, req_ready=1.
//  - Load timing: cycle 1..L+1 ram_read=1, ram_addr=A+i (i=0..L), one address per cycle, no gaps.
//    ram_rdata valid cycle after its strobe; MDR captures it; rsp_valid for word i in cycle i+3.
//    rsp_last with word L. req_ready returns cycle after rsp_last (back-to-back loads have 1 idle cycle min).
//  - Valid/last travel in a 2-stage shift pipeline aligned to ram latency + MDR.
//  - Address arithmetic modulo 2^ADDR_W: burst from 0x1FE len 3 issues 0x1FE,0x1FF,0x000,0x001.
//  - rsp_data holds last value when rsp_valid=0; wr_done and rsp_valid never high together.
//  - Reset mid-burst: immediate abort, ram strobes drop asynchronously, no further rsp_valid/rsp_last/wr_done.
//  - req_valid high while busy: held off (req_ready=0), never lost or merged.
// STRUCTURE
//  - Shared package mini_cpu_mem_pkg: ADDR_W/DATA_W/LEN_W constants, FSM state encoding (IDLE, WRITE, READ, DRAIN).
//  - One sub-module: mem_rsp_pipe (2-stage valid/last shift + MDR capture); FSM, MAR, counter in top.
// TESTING (bench includes a behavioural 1-cycle-read ram model)
//  1 Store: we=1 A=0x08E D=0x34 -> cycle1 ram_write=1 addr=0x08E; cycle2 wr_done=1; model mem[0x08E]=0x34.
//  2 Single load: mem[0x047]=0x94, A=0x047 len=0 -> cycle3 rsp_valid=1 rsp_last=1 rsp_data=0x94; ready cycle4.
//  3 Burst: mem[10..13]=1,2,3,4, A=10 len=3 -> ram_read cycles1-4, rsp_data 1,2,3,4 cycles3-6, last only with 4.
//  4 Wrap: A=0x1FE len=3 -> ram_addr 0x1FE,0x1FF,0x000,0x001; 4 responses in order.
//  5 Reset mid-burst: clear_n low in cycle 3 of len=7 load -> all outputs 0 same cycle; no rsp after release.
//  6 Back-pressure: req_valid held during burst with new store -> req_ready=0 until done; store issued exactly once.

Source files
------------

// File: rtl/mini_cpu_mem_pkg.sv
// Shared constants and FSM encoding for the main-memory port controller.
package mini_cpu_mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Load response pipeline: two-stage valid/last shift aligned to the ram read
// latency, plus the MDR that captures ram read data one cycle after the strobe.
module mem_rsp_pipe
  import mini_cpu_mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              issue_valid,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              s1_valid,
  output logic              rsp_valid,
  output logic              rsp_last,
  output logic [DATA_W-1:0] rsp_data
);

  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q,  s1_last_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_last_q,  s2_last_d;
  logic [DATA_W-1:0] mdr_q,      mdr_d;

  always_comb begin
    s1_valid_d = issue_valid;
    s1_last_d  = issue_valid & issue_last;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q;
    // ram data is valid while stage 1 holds the matching strobe; otherwise MDR holds.
    mdr_d      = s1_valid_q ? ram_rdata : mdr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift work.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      mdr_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      mdr_q      <= mdr_d;
    end
  end

  assign s1_valid  = s1_valid_q;
  assign rsp_valid = s2_valid_q;
  assign rsp_last  = s2_last_q;
  assign rsp_data  = mdr_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// Initiator side of the main-memory port: single-word stores and 1..16-word
// burst loads turned into registered ram strobes, with load data on a response stream.
module mem_port_ctrl
  import mini_cpu_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = MEM_LEN_W
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic              wr_done_q, wr_done_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              issue_last;
  logic              s1_valid;

  // The strobe currently on the bus is the final one of the burst.
  assign issue_last = (count_q == '0);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    wr_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          mar_d = req_addr;
          if (req_we) begin
            state_d     = ST_WRITE;
            wdata_d     = req_wdata;
            ram_write_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            count_d    = req_len;
            ram_read_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        state_d   = ST_IDLE;
        wr_done_d = 1'b1;
      end
      ST_READ: begin
        if (count_q == '0) begin
          state_d = ST_DRAIN;
        end else begin
          ram_read_d = 1'b1;
          mar_d      = mar_q + 1'b1;
          count_d    = count_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        // Stage 2 empties on this same edge, so only stage 1 gates the exit.
        if (!s1_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE) | ram_read_q | s1_valid;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      mar_q       <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      wr_done_q   <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      wr_done_q   <= wr_done_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  mem_rsp_pipe #(
    .DATA_W (DATA_W)
  ) u_rsp_pipe (
    .clock       (clock),
    .clear_n     (clear_n),
    .issue_valid (ram_read_q),
    .issue_last  (issue_last),
    .ram_rdata   (ram_rdata),
    .s1_valid    (s1_valid),
    .rsp_valid   (rsp_valid),
    .rsp_last    (rsp_last),
    .rsp_data    (rsp_data)
  );

  assign req_ready = req_ready_q;
  assign wr_done   = wr_done_q;
  assign busy      = busy_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = mar_q;
  assign ram_wdata = wdata_q;

endmodule
